int8_shift_seq: RTL and testbench
=================================

INT8_SHIFT_SEQ -- requirements
Module: int8_shift_seq

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on the rising edge.
REQ-002 SHALL provide: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide: start  in  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL provide: dir  in  1  direction: 0 = left, 1 = right.
REQ-005 SHALL provide: mode  in  2  operation: 00 logical shift, 01 rotate, 10 rotate-through-carry, 11 arithmetic.
REQ-006 SHALL provide: cnt  in  3  bit positions to move, 0..7.
REQ-007 SHALL provide: a  in  8  operand.
REQ-008 SHALL provide: cin  in  1  carry-in, used by mode 10 and by the cnt=0 case.
REQ-009 SHALL provide: y  out  8  result, registered.
REQ-010 SHALL provide: cout  out  1  carry-out, registered.
REQ-011 SHALL provide: zero  out  1  y == 8'h00, registered.
REQ-012 SHALL provide: busy  out  1  high in SHIFT and DONE.
REQ-013 SHALL provide: done  out  1  single-cycle pulse when the result is valid.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch a, cin, dir, mode and cnt.
REQ-016 On that IDLE start, the FSM SHALL go to SHIFT if cnt≠0, otherwise to DONE.
REQ-017 Each SHIFT cycle SHALL apply exactly one single-bit step to the working value and carry, then decrement the remaining count.
REQ-018 The FSM SHALL leave SHIFT for DONE on the cycle the remaining count reaches 0.
REQ-019 Latency SHALL be fixed: start sampled at edge T gives done=1 in the cycle after edge T+cnt+1. For cnt=0, done=1 in the cycle after edge T+1.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE; y, cout and zero SHALL hold their values until the next accepted start.
REQ-021 Single-bit step, logical: left is {v[6:0],0} with carry=v[7]; right is {0,v[7:1]} with carry=v[0].
REQ-022 Single-bit step, rotate: left is {v[6:0],v[7]} with carry=v[7]; right is {v[0],v[7:1]} with carry=v[0].
REQ-023 Single-bit step, rotate-through-carry: left is {v[6:0],c} with carry=v[7]; right is {c,v[7:1]} with carry=v[0].
REQ-024 Single-bit step, arithmetic: right is {v[7],v[7:1]} with carry=v[0]; left is identical to logical left.
REQ-025 With cnt=0, y SHALL equal a, cout SHALL equal cin, and zero SHALL equal (a==0).
REQ-026 start SHALL be ignored while busy=1; no queuing and no restart.
REQ-027 Input changes after the accepting edge SHALL NOT affect an operation in flight.
REQ-028 All arithmetic SHALL be 8-bit with no width extension; the working count SHALL be 3 bits.

Reset
REQ-029 With rst=1 at an edge, the FSM SHALL go to IDLE and y=8'h00, cout=0, zero=1, busy=0, done=0.
REQ-030 Reset mid-operation SHALL abort the operation with no done pulse; busy SHALL be 0 in the cycle after the reset edge.
REQ-031 rst SHALL take priority over start at the same edge.

Structure
REQ-032 A shared package int8_pkg SHALL hold the mode constants (MODE_LSH, MODE_ROT, MODE_RCT, MODE_ASH), the direction constants and the FSM state encoding.
REQ-033 The single-bit step SHALL be one combinational sub-module, int8_shift1 (inputs v, c, dir, mode; outputs v_next, c_next), instantiated once.

Verification
REQ-034 a=8'h96, dir=0, mode=00, cnt=3 -> y=8'hB0, cout=0, zero=0; done 4 cycles after start.
REQ-035 a=8'h81, dir=1, mode=01, cnt=1 -> y=8'hC0, cout=1; done 2 cycles after start.
REQ-036 a=8'h80, dir=1, mode=11, cnt=7 -> y=8'hFF, cout=0; busy high for 8 cycles.
REQ-037 a=8'h00, cin=1, dir=0, mode=10, cnt=2 -> y=8'h02, cout=0. Same inputs with cnt=0 -> y=8'h00, cout=1, zero=1.
REQ-038 Start a cnt=7 operation, pulse start again at cycle 3, assert rst at cycle 5 -> the second start is ignored, no done pulse occurs, busy=0 at cycle 6, and y=8'h00 with zero=1.
REQ-039 Drive a back-to-back start in the cycle immediately after done -> accepted; the new result appears after the REQ-019 latency.

Source files
------------

// File: rtl/int8_pkg.sv
// Shared constants for the 8-bit sequential shifter: operation modes,
// shift directions and the controller state encoding.
package int8_pkg;

   localparam logic [1:0] MODE_LSH = 2'b00;
   localparam logic [1:0] MODE_ROT = 2'b01;
   localparam logic [1:0] MODE_RCT = 2'b10;
   localparam logic [1:0] MODE_ASH = 2'b11;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/int8_shift1.sv
// One single-bit shift/rotate step on an 8-bit value plus carry.
// Purely combinational; the sequencer applies it once per SHIFT cycle.
module int8_shift1
   import int8_pkg::*;
(
   input  logic [7:0] v,
   input  logic       c,
   input  logic       dir,
   input  logic [1:0] mode,
   output logic [7:0] v_next,
   output logic       c_next
);

   // The carry always receives the bit that falls off the end being vacated.
   always_comb begin
      v_next = v;
      c_next = (dir == DIR_RIGHT) ? v[0] : v[7];
      case (mode)
         MODE_LSH: v_next = (dir == DIR_RIGHT) ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
         MODE_ROT: v_next = (dir == DIR_RIGHT) ? {v[0], v[7:1]} : {v[6:0], v[7]};
         MODE_RCT: v_next = (dir == DIR_RIGHT) ? {c, v[7:1]}    : {v[6:0], c};
         MODE_ASH: v_next = (dir == DIR_RIGHT) ? {v[7], v[7:1]} : {v[6:0], 1'b0};
         default:  v_next = v;
      endcase
   end

endmodule

// File: rtl/int8_shift_seq.sv
// Multi-cycle 8-bit shifter: latches an operation on start, applies one
// single-bit step per cycle, then publishes y/cout/zero with a done pulse.
module int8_shift_seq
   import int8_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dir,
   input  logic [1:0] mode,
   input  logic [2:0] cnt,
   input  logic [7:0] a,
   input  logic       cin,
   output logic [7:0] y,
   output logic       cout,
   output logic       zero,
   output logic       busy,
   output logic       done
);

   state_t     state;
   logic [7:0] work_v;
   logic       work_c;
   logic       dir_q;
   logic [1:0] mode_q;
   logic [2:0] rem;
   logic [7:0] step_v;
   logic       step_c;

   int8_shift1 u_shift1 (
      .v      (work_v),
      .c      (work_c),
      .dir    (dir_q),
      .mode   (mode_q),
      .v_next (step_v),
      .c_next (step_c)
   );

   // Results only update on leaving DONE, so y/cout/zero stay stable while
   // a new operation is being worked on internally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         work_v <= 8'h00;
         work_c <= 1'b0;
         dir_q  <= DIR_LEFT;
         mode_q <= MODE_LSH;
         rem    <= 3'd0;
         y      <= 8'h00;
         cout   <= 1'b0;
         zero   <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  work_v <= a;
                  work_c <= cin;
                  dir_q  <= dir;
                  mode_q <= mode;
                  rem    <= cnt;
                  busy   <= 1'b1;
                  state  <= (cnt != 3'd0) ? ST_SHIFT : ST_DONE;
               end
            end
            ST_SHIFT: begin
               work_v <= step_v;
               work_c <= step_c;
               rem    <= rem - 3'd1;
               if (rem == 3'd1) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               y     <= work_v;
               cout  <= work_c;
               zero  <= (work_v == 8'h00);
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int8_shift_seq.sv
// Scoreboard bench for int8_shift_seq: a closed-form shift model predicts
// each result and its done cycle; a negedge monitor checks every done pulse.
module tb_int8_shift_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic       dir;
   logic [1:0] mode;
   logic [2:0] cnt;
   logic [7:0] a;
   logic       cin;
   logic [7:0] y;
   logic       cout;
   logic       zero;
   logic       busy;
   logic       done;

   typedef struct {
      logic [7:0] y;
      logic       cout;
      logic       zero;
      int         done_cycle;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   int8_shift_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .dir   (dir),
      .mode  (mode),
      .cnt   (cnt),
      .a     (a),
      .cin   (cin),
      .y     (y),
      .cout  (cout),
      .zero  (zero),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Whole-operation view: shifting by n is a wide shift / rotate of the
   // operand (optionally with the carry as a ninth bit), not n steps.
   function automatic exp_t model(input logic [7:0] av, input logic c, input logic d,
                                  input logic [1:0] m, input logic [2:0] n);
      exp_t       e;
      logic [15:0] w;
      logic [8:0]  r;
      int          s;
      s = int'(n);
      e.y = av;
      e.cout = c;
      e.done_cycle = 0;
      if (n != 3'd0) begin
         case (m)
            2'b01: begin
               w = {av, av};
               if (!d) begin w = w << s; e.y = w[15:8]; e.cout = e.y[0]; end
               else    begin w = w >> s; e.y = w[7:0];  e.cout = e.y[7]; end
            end
            2'b10: begin
               r = {c, av};
               if (!d) r = (r << s) | (r >> (9 - s));
               else    r = (r >> s) | (r << (9 - s));
               e.y = r[7:0];
               e.cout = r[8];
            end
            default: begin
               if (!d) begin
                  w = {8'h00, av} << s;
                  e.y = w[7:0];
                  e.cout = w[8];
               end else if (m == 2'b00) begin
                  w = {av, 8'h00} >> s;
                  e.y = w[15:8];
                  e.cout = w[7];
               end else begin
                  w = $signed({av, 8'h00}) >>> s;
                  e.y = w[15:8];
                  e.cout = w[7];
               end
            end
         endcase
      end
      e.zero = (e.y == 8'h00);
      return e;
   endfunction

   // Issues one operation, scrambles inputs while it runs, optionally pokes
   // start mid-flight, and returns in the done cycle so the next call is
   // back-to-back.
   task automatic applyStimulus(input logic [7:0] a_i, input logic cin_i, input logic dir_i,
                                input logic [1:0] mode_i, input logic [2:0] cnt_i, input int ign_at);
      exp_t e;
      int   busy_cycles;
      bit   seen;
      @(negedge clk);
      a = a_i; cin = cin_i; dir = dir_i; mode = mode_i; cnt = cnt_i; start = 1'b1;
      e = model(a_i, cin_i, dir_i, mode_i, cnt_i);
      e.done_cycle = cyc + 1 + int'(cnt_i) + 1;
      exp_q.push_back(e);
      busy_cycles = 0;
      seen = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         start = (k == ign_at) && busy;
         a = 8'($urandom); cin = 1'($urandom); dir = 1'($urandom);
         mode = 2'($urandom); cnt = 3'($urandom);
         if (busy) busy_cycles++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      checkOutput("done_timeout", 32'(seen), 32'd1);
      checkOutput("busy_cycles", 32'(busy_cycles), 32'(int'(cnt_i) + 1));
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("y", 32'(y), 32'(e.y));
               checkOutput("cout", 32'(cout), 32'(e.cout));
               checkOutput("zero", 32'(zero), 32'(e.zero));
               checkOutput("latency", 32'(cyc), 32'(e.done_cycle));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; dir = 1'b0; mode = 2'b00; cnt = 3'd0; a = 8'h00; cin = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_y", 32'(y), 32'h00);
      checkOutput("reset_cout", 32'(cout), 32'd0);
      checkOutput("reset_zero", 32'(zero), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      rst = 1'b0;

      applyStimulus(8'h96, 1'b0, 1'b0, 2'b00, 3'd3, 0);
      applyStimulus(8'h81, 1'b0, 1'b1, 2'b01, 3'd1, 0);
      applyStimulus(8'h80, 1'b1, 1'b1, 2'b11, 3'd7, 3);
      applyStimulus(8'h00, 1'b1, 1'b0, 2'b10, 3'd2, 0);
      applyStimulus(8'h00, 1'b1, 1'b0, 2'b10, 3'd0, 1);
      applyStimulus(8'h5A, 1'b1, 1'b1, 2'b10, 3'd0, 0);
      applyStimulus(8'hC3, 1'b1, 1'b1, 2'b10, 3'd5, 2);
      applyStimulus(8'h01, 1'b0, 1'b0, 2'b01, 3'd7, 0);

      for (int i = 0; i < 40; i++) begin
         applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                       3'($urandom), int'($urandom_range(0, 8)));
      end

      applyStimulus(8'h96, 1'b0, 1'b0, 2'b00, 3'd3, 0);

      // Abort a cnt=7 operation with reset; start asserted with reset loses.
      @(negedge clk);
      a = 8'h7F; cin = 1'b1; dir = 1'b1; mode = 2'b01; cnt = 3'd7; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; a = 8'h11; cnt = 3'd0;
      @(negedge clk); start = 1'b0;
      checkOutput("busy_before_abort", 32'(busy), 32'd1);
      @(negedge clk); rst = 1'b1; start = 1'b1;
      @(negedge clk); rst = 1'b0; start = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_y", 32'(y), 32'h00);
      checkOutput("abort_zero", 32'(zero), 32'd1);
      checkOutput("abort_cout", 32'(cout), 32'd0);
      repeat (12) @(negedge clk);
      checkOutput("idle_after_abort", 32'(busy), 32'd0);

      applyStimulus(8'h81, 1'b0, 1'b1, 2'b01, 3'd1, 0);
      repeat (4) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
